// File: rtl/aes_key_expand_ctrl.sv
// Sequences a single-round AES-128 key-schedule unit ten times and keeps K0..K10 in a key store.
// Round keys are read back through a registered port with 1-cycle latency; a new start is ignored while busy.
module aes_key_expand_ctrl #(
  parameter int unsigned KS_LAT = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  logic [0:127] key_in,
  output logic         busy,
  output logic         done,
  output logic         ready,
  output logic         ks_load,
  output logic [0:3]   ks_round,
  output logic [0:127] ks_keyin,
  input  logic [0:127] ks_keyout,
  input  logic         rk_rd,
  input  logic [0:3]   rk_idx,
  output logic         rk_rvalid,
  output logic         rk_rerr,
  output logic [0:127] rk_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   wcnt_q, wcnt_d;
  logic [3:0]   wr_cnt_q, wr_cnt_d;
  logic [0:127] keyin_q, keyin_d;

  logic         key_we;
  logic [3:0]   key_waddr;
  logic [0:127] key_wdata;
  logic [0:127] key_q [11];

  logic         rd_legal;
  logic [3:0]   rd_sel;
  logic         rk_rvalid_q;
  logic         rk_rerr_q;
  logic [0:127] rk_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rnd_q    <= 4'd0;
      wcnt_q   <= 4'd0;
      wr_cnt_q <= 4'd0;
      keyin_q  <= '0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      wcnt_q   <= wcnt_d;
      wr_cnt_q <= wr_cnt_d;
      keyin_q  <= keyin_d;
    end
  end

  // The key driven to the unit is tracked in its own register, so it never has to be muxed out of the store.
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    wcnt_d    = wcnt_q;
    wr_cnt_d  = wr_cnt_q;
    keyin_d   = keyin_q;
    key_we    = 1'b0;
    key_waddr = 4'd0;
    key_wdata = ks_keyout;
    if (flush) begin
      state_d  = S_IDLE;
      wr_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            key_we    = 1'b1;
            key_waddr = 4'd0;
            key_wdata = key_in;
            keyin_d   = key_in;
            wr_cnt_d  = 4'd1;
            rnd_d     = 4'd0;
            state_d   = S_LOAD;
          end
        end
        S_LOAD: begin
          wcnt_d  = 4'(KS_LAT);
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (wcnt_q <= 4'd1) state_d = S_CAPT;
          else                wcnt_d  = wcnt_q - 4'd1;
        end
        S_CAPT: begin
          key_we    = 1'b1;
          key_waddr = rnd_q + 4'd1;
          key_wdata = ks_keyout;
          keyin_d   = ks_keyout;
          wr_cnt_d  = (wr_cnt_q < 4'd11) ? wr_cnt_q + 4'd1 : wr_cnt_q;
          if (rnd_q >= 4'd9) begin
            state_d = S_DONE;
          end else begin
            rnd_d   = rnd_q + 4'd1;
            state_d = S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (key_we) key_q[key_waddr] <= key_wdata;
  end

  // wr_cnt never exceeds 11, so this also rejects indices 11..15; a same-cycle capture is not yet counted.
  assign rd_legal = (rk_idx < wr_cnt_q);
  assign rd_sel   = rd_legal ? rk_idx : 4'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rk_rvalid_q <= 1'b0;
      rk_rerr_q   <= 1'b0;
      rk_data_q   <= '0;
    end else begin
      rk_rvalid_q <= rk_rd;
      rk_rerr_q   <= rk_rd & ~rd_legal;
      rk_data_q   <= (rk_rd && rd_legal) ? key_q[rd_sel] : '0;
    end
  end

  assign busy      = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_CAPT);
  assign ready     = (state_q == S_DONE);
  assign done      = (state_q == S_CAPT) && (rnd_q == 4'd9) && !flush;
  assign ks_load   = (state_q == S_LOAD);
  assign ks_round  = rnd_q;
  assign ks_keyin  = keyin_q;
  assign rk_rvalid = rk_rvalid_q;
  assign rk_rerr   = rk_rerr_q;
  assign rk_data   = rk_data_q;

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Bench for aes_key_expand_ctrl: models the key-schedule unit with full AES arithmetic and checks sequencing and reads.
module tb_aes_key_expand_ctrl;

  localparam int KS_LAT  = 7;
  localparam int RND_CYC = KS_LAT + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [0:127] key_in = '0;
  logic         busy, done, ready, ks_load;
  logic [0:3]   ks_round;
  logic [0:127] ks_keyin;
  logic [0:127] ks_keyout = '0;
  logic         rk_rd = 1'b0;
  logic [0:3]   rk_idx = '0;
  logic         rk_rvalid, rk_rerr;
  logic [0:127] rk_data;

  int checks = 0;
  int failures = 0;

  aes_key_expand_ctrl #(.KS_LAT(KS_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .key_in(key_in),
    .busy(busy), .done(done), .ready(ready), .ks_load(ks_load),
    .ks_round(ks_round), .ks_keyin(ks_keyin), .ks_keyout(ks_keyout),
    .rk_rd(rk_rd), .rk_idx(rk_idx), .rk_rvalid(rk_rvalid), .rk_rerr(rk_rerr),
    .rk_data(rk_data)
  );

  initial forever #5 clk = ~clk;

  // AES arithmetic: S-box from the GF(2^8) inverse (x^254) plus the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] hi, lo;
    hi = b << n;
    lo = b >> (8 - n);
    return hi | lo;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [0:127] next_key(input logic [0:127] k, input int r);
    logic [31:0] w0, w1, w2, w3, tw, n0, n1, n2, n3;
    logic [7:0]  rc;
    w0 = k[0 +: 32]; w1 = k[32 +: 32]; w2 = k[64 +: 32]; w3 = k[96 +: 32];
    rc = 8'h01;
    for (int i = 0; i < r; i++) rc = gmul(rc, 8'h02);
    tw = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = w0 ^ tw; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [0:127] mk [11];

  task automatic expand_model(input logic [0:127] k);
    mk[0] = k;
    for (int r = 0; r < 10; r++) mk[r + 1] = next_key(mk[r], r);
  endtask

  // Keys captured so far during cycle tt of an expansion (cycle 1 is the first LOAD).
  function automatic int exp_wr(input int tt);
    int w;
    if (tt < 1) return 0;
    w = 1 + (tt - 1) / RND_CYC;
    return (w > 11) ? 11 : w;
  endfunction

  // Key-schedule unit: output is garbage until KS_LAT cycles after the load pulse ends.
  int           u_cnt = 0;
  logic [0:127] u_pend;
  always @(negedge clk) begin
    if (!rst) begin
      u_cnt = 0;
    end else if (ks_load) begin
      u_pend    = next_key(ks_keyin, int'(ks_round));
      u_cnt     = KS_LAT + 1;
      ks_keyout = {$urandom, $urandom, $urandom, $urandom};
    end else if (u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) ks_keyout = u_pend;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int           t = 0;
  int           load_rnd[$];
  int           n_done = 0;
  int           done_t = -1;
  int           stable_bad = 0;
  int           keyin_bad = 0;
  logic [0:3]   last_rnd = '0;
  logic [0:127] last_keyin = '0;
  logic [0:127] keyin_r1 = '0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    t++;
    if (ks_load) begin
      load_rnd.push_back(int'(ks_round));
      if (ks_keyin !== mk[ks_round]) keyin_bad++;
      if (ks_round == 4'd1) keyin_r1 = ks_keyin;
      last_rnd   = ks_round;
      last_keyin = ks_keyin;
    end else if (busy && (ks_round !== last_rnd || ks_keyin !== last_keyin)) begin
      stable_bad++;
    end
    if (done) begin
      n_done++;
      if (done_t < 0) done_t = t;
    end
  endtask

  task automatic start_exp(input logic [0:127] k);
    expand_model(k);
    load_rnd.delete();
    n_done = 0; done_t = -1; stable_bad = 0; keyin_bad = 0; t = 0;
    start = 1'b1; key_in = k;
    step();
    start = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, output logic v, output logic e, output logic [0:127] d);
    rk_rd = 1'b1; rk_idx = idx;
    step();
    rk_rd = 1'b0;
    v = rk_rvalid; e = rk_rerr; d = rk_data;
  endtask

  task automatic chk_read(input string name, input logic [3:0] idx, input int issue_t);
    logic legal;
    legal = (int'(idx) < exp_wr(issue_t));
    chk({name, "_vld"}, rk_rvalid, 1'b1);
    chk({name, "_err"}, rk_rerr, !legal);
    chk({name, "_dat"}, rk_data, legal ? mk[idx] : 128'h0);
  endtask

  typedef struct {
    logic         rd;
    logic [3:0]   idx;
    logic         vld;
    logic         err;
    logic [0:127] dat;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic         v, e;
    logic [0:127] d;
    logic [0:127] fips_key, seq_key;
    logic [3:0]   ri;
    logic         pend;
    int           issue_t, nloads;

    fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    seq_key  = 128'h000102030405060708090a0b0c0d0e0f;
    tbl[0] = '{1'b1, 4'd0,  1'b1, 1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    tbl[1] = '{1'b1, 4'd1,  1'b1, 1'b0, 128'ha0fafe1788542cb123a339392a6c7605};
    tbl[2] = '{1'b1, 4'd10, 1'b1, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[3] = '{1'b0, 4'd2,  1'b0, 1'b0, 128'h0};
    tbl[4] = '{1'b1, 4'd11, 1'b1, 1'b1, 128'h0};
    tbl[5] = '{1'b1, 4'd15, 1'b1, 1'b1, 128'h0};
    tbl[6] = '{1'b1, 4'd2,  1'b1, 1'b0, 128'hf2c295f27a96b9435935807a7359f67f};

    #1 rst = 1'b0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ks_load", ks_load, 1'b0);
    chk("rst_ks_round", ks_round, 4'd0);
    chk("rst_ks_keyin", ks_keyin, 128'h0);
    chk("rst_rvalid_rerr", {rk_rvalid, rk_rerr}, 2'b00);
    chk("rst_rk_data", rk_data, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    rd(4'd0, v, e, d);
    chk("empty_rd0_vld", v, 1'b1);
    chk("empty_rd0_err", e, 1'b1);
    chk("empty_rd0_dat", d, 128'h0);

    // Reference expansion with an ignored start at cycle 20 and reads straddling the 3rd capture.
    start_exp(fips_key);
    while (n_done == 0 && t < 400) begin
      start  = (t == 20);
      key_in = (t == 20) ? seq_key : fips_key;
      pend   = (t >= 27 && t <= 30);
      ri     = (t <= 28) ? 4'd3 : ((t == 29) ? 4'd4 : 4'd11);
      rk_rd  = pend; rk_idx = ri; issue_t = t;
      step();
      if (pend) chk_read("mid_rd", ri, issue_t);
    end
    start = 1'b0; rk_rd = 1'b0;
    chk("done_cycle", done_t, 10 * RND_CYC);
    step();
    chk("post_done_ready", ready, 1'b1);
    chk("post_done_busy", busy, 1'b0);
    chk("done_pulses", n_done, 1);
    chk("load_count", load_rnd.size(), 10);
    for (int r = 0; r < 10; r++)
      chk("ks_round_seq", (r < load_rnd.size()) ? load_rnd[r] : -1, r);
    chk("keyin_round1", keyin_r1, 128'ha0fafe1788542cb123a339392a6c7605);
    chk("keyin_per_round", keyin_bad, 0);
    chk("keyin_round_stable", stable_bad, 0);

    for (int i = 0; i < 7; i++) begin
      rk_rd = tbl[i].rd; rk_idx = tbl[i].idx;
      step();
      chk("tbl_vld", rk_rvalid, tbl[i].vld);
      chk("tbl_err", rk_rerr, tbl[i].err);
      chk("tbl_dat", rk_data, tbl[i].dat);
    end
    rk_rd = 1'b0;

    // flush together with start while DONE: flush wins.
    flush = 1'b1; start = 1'b1; key_in = seq_key;
    step();
    flush = 1'b0; start = 1'b0;
    chk("flush_done_ready", ready, 1'b0);
    chk("flush_start_busy", busy, 1'b0);
    rd(4'd0, v, e, d);
    chk("flush_done_rd0_err", e, 1'b1);

    // flush mid-expansion.
    start_exp(fips_key);
    while (t < 40) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_mid_busy", busy, 1'b0);
    chk("flush_mid_ready_done", {ready, done}, 2'b00);
    rd(4'd0, v, e, d);
    chk("flush_mid_rd0_err", e, 1'b1);
    chk("flush_mid_rd0_dat", d, 128'h0);
    nloads = load_rnd.size();
    for (int i = 0; i < 60; i++) step();
    chk("flush_mid_no_loads", load_rnd.size(), nloads);
    chk("flush_mid_no_done", n_done, 0);

    // Random keys, random reads and ignored start pulses during expansion.
    for (int n = 0; n < 4; n++) begin
      start_exp({$urandom, $urandom, $urandom, $urandom});
      while (n_done == 0 && t < 400) begin
        start  = ($urandom_range(19, 0) == 0);
        key_in = {$urandom, $urandom, $urandom, $urandom};
        pend   = ($urandom_range(2, 0) == 0);
        ri     = 4'($urandom_range(15, 0));
        rk_rd  = pend; rk_idx = ri; issue_t = t;
        step();
        if (pend) chk_read("rnd_mid_rd", ri, issue_t);
      end
      start = 1'b0; rk_rd = 1'b0;
      chk("rnd_done_cycle", done_t, 10 * RND_CYC);
      chk("rnd_keyin_per_round", keyin_bad, 0);
      step();
      for (int i = 0; i < 16; i++) begin
        ri = 4'($urandom_range(15, 0));
        rk_rd = 1'b1; rk_idx = ri; issue_t = 200;
        step();
        chk_read("rnd_full_rd", ri, issue_t);
      end
      rk_rd = 1'b0;
    end

    // Asynchronous reset mid-expansion, then re-expansion.
    start_exp(seq_key);
    while (t < 49) step();
    rd(4'd0, v, e, d);
    chk("pre_rst_rd0", d, seq_key);
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_ready_done_load", {ready, done, ks_load}, 3'b000);
    chk("arst_ks_round", ks_round, 4'd0);
    chk("arst_ks_keyin", ks_keyin, 128'h0);
    chk("arst_rvalid_rerr", {rk_rvalid, rk_rerr}, 2'b00);
    chk("arst_rk_data", rk_data, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    start_exp(seq_key);
    while (n_done == 0 && t < 400) step();
    chk("restart_done_cycle", done_t, 10 * RND_CYC);
    step();
    rd(4'd10, v, e, d);
    chk("restart_k10_err", e, 1'b0);
    chk("restart_k10_dat", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule

// File: doc/aes_key_expand_ctrl.md
# aes_key_expand_ctrl

Sequencer for the team's single-round AES-128 key-schedule unit. On `start` it runs that unit ten times, feeding each round key back in to produce the next, and stores all 11 round keys (K0..K10) in an internal key store. The cipher round datapath then reads the keys by index through a registered read port. The block sits between the top-level key input and both the key-schedule unit and the encrypt/decrypt round controller.

## Interface
- `KS_LAT`, default 7: cycles from the end of the `ks_load` pulse to a valid `ks_keyout`. Legal range 1..15.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: begin expansion of `key_in`; sampled only in IDLE or DONE.
- `flush` input 1: synchronous abort; returns to IDLE and invalidates the store.
- `key_in` input [0:127]: cipher key; bits [0:7] are byte 0. Captured on accepted `start`.
- `busy` output 1: high from accepted `start` until the K10 capture.
- `done` output 1: one-cycle pulse when K10 is stored.
- `ready` output 1: level, high while all 11 keys are valid.
- `ks_load` output 1: load/restart pulse to the key-schedule unit.
- `ks_round` output [0:3]: round number 0..9 for the Rcon selection.
- `ks_keyin` output [0:127]: previous round key driven to the unit.
- `ks_keyout` input [0:127]: next round key from the unit.
- `rk_rd` input 1: read request.
- `rk_idx` input [0:3]: round key index 0..10.
- `rk_rvalid` output 1: read response strobe, one cycle after `rk_rd`.
- `rk_rerr` output 1: asserted with `rk_rvalid` when the index is illegal or not yet written.
- `rk_data` output [0:127]: read data; 0 when `rk_rerr` is high.

## Operation
- FSM states: IDLE, LOAD, WAIT, CAPT, DONE.
- IDLE/DONE + `start`:
  - K0 is written with `key_in` and `wr_cnt` is set to 1.
  - `rnd` is set to 0, `busy` rises, `ready` falls, and the FSM goes to LOAD.
- LOAD (1 cycle): `ks_load`=1, `ks_round`=`rnd`, `ks_keyin`=K[`rnd`]. Go to WAIT and load `wcnt`=KS_LAT.
- WAIT:
  - `ks_load`=0, while `ks_keyin` and `ks_round` are held stable.
  - `wcnt` decrements each cycle; when it reaches 1, go to CAPT.
- CAPT (1 cycle):
  - K[`rnd`+1] is written with `ks_keyout` and `wr_cnt` increments.
  - If `rnd`=9: go to DONE, pulse `done`, drop `busy`, raise `ready`.
  - Otherwise: `rnd` increments and the FSM goes to LOAD.
- DONE: hold with `ready`=1. A new `start` re-expands exactly as it does from IDLE.
- `start` while `busy` is ignored; no queuing.
- `flush` in any state:
  - Next state is IDLE, `wr_cnt` is set to 0, and `busy`/`ready`/`done` are set to 0.
  - The key store contents are left unchanged but become unreadable.
- `flush` has priority over `start` in the same cycle.
- Read port:
  - A read is legal when `rk_idx` < `wr_cnt`, which allows reads of already-captured keys mid-expansion.
  - For a legal read: `rk_data`=K[`rk_idx`] and `rk_rerr`=0.
  - If `rk_idx` ≥ 11 or `rk_idx` ≥ `wr_cnt`: `rk_rerr`=1 and `rk_data`=0.
  - A read and a capture of the same index in the same cycle returns error; the write is not bypassed.
- Arithmetic: `rnd` is 4 bits and saturates at 9, `wr_cnt` is 4 bits with range 0..11, `wcnt` is 4 bits. There is no wrap-around.

## Timing
- Reset values: `busy`, `done`, `ready`, `ks_load`, `rk_rvalid` and `rk_rerr` are 0; `ks_round`=0; `ks_keyin`=0; `rk_data`=0. The FSM is in IDLE and `wr_cnt`=0.
- `start` sampled at edge 0 → LOAD at cycle 1.
- Each round takes 1+KS_LAT+1 cycles (9 cycles at the default).
- `done` pulses in cycle 10·(KS_LAT+2), which is cycle 90 at the default.
- `ready` is high from the cycle after the final CAPT.
- `ks_load` is a single-cycle pulse per round, 10 pulses per expansion.
- Read latency is 1 cycle. `rk_rvalid` is high for exactly one cycle per `rk_rd`, and back-to-back reads are supported.
- Asserting `rst` low mid-operation clears all state immediately, regardless of the clock.

## Test plan
- Reset, then read `rk_idx`=0: `rk_rvalid`=1 and `rk_rerr`=1 one cycle later, with `rk_data`=0.
- `key_in`=2b7e151628aed2a6abf7158809cf4f3c, `start`, unit model has KS_LAT=7:
  - `done` pulses at cycle 90.
  - Read 1 → a0fafe1788542cb123a339392a6c7605.
  - Read 10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- Check the sequencing during that expansion:
  - Exactly 10 `ks_load` pulses with `ks_round`=0..9.
  - `ks_keyin` at round 1 = a0fafe17….
- Mid-expansion, just after the 3rd CAPT (`wr_cnt`=4):
  - Read 3 → valid key.
  - Read 4 → `rk_rerr`=1.
  - Read 11 → `rk_rerr`=1 at any time.
- Reject and abort behaviour:
  - `start` pulsed at cycle 20 of an expansion → ignored, and `done` still falls at cycle 90.
  - `flush` at cycle 40 → IDLE next cycle, `busy`=0, read 0 → error.
- Restart behaviour:
  - Asserting `rst` low at cycle 50 → all outputs are 0 immediately.
  - Re-`start` with key 000102030405060708090a0b0c0d0e0f → K10 = 13111d7fe3944a17f307a78b4d2b30c5.
